// File: rtl/intr_ctrl_if.sv
// CPU-side bus and interrupt handshake signals of the interrupt controller.
// The shared tri-state data bus stays a plain inout port on the controller.
interface intr_ctrl_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] address;
    logic             wrtEn;
    logic             intAck;
    logic             intReq;
    logic [4:0]       intNum;

    modport master (
        output address,
        output wrtEn,
        output intAck,
        input  intReq,
        input  intNum
    );

    modport slave (
        input  address,
        input  wrtEn,
        input  intAck,
        output intReq,
        output intNum
    );
endinterface

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: rising-edge pending latch, enable mask, and a
// fixed-priority (lowest index wins) request/acknowledge/EOI handshake to the CPU.
module intr_ctrl #(
    parameter int unsigned      DBITS    = 32,
    parameter int unsigned      NSRC     = 8,
    parameter logic [DBITS-1:0] ENBASE   = 32'hF000_0200,
    parameter logic [DBITS-1:0] PENDBASE = 32'hF000_0204,
    parameter logic [DBITS-1:0] CTRLBASE = 32'hF000_0208
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DBITS-1:0]  dbus,
    input  logic [NSRC-1:0]   irqSrc,
    intr_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e          state_q, state_d;
    logic [NSRC-1:0] en_q, en_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] prev_q;
    logic            gie_q, gie_d;
    logic            req_q, req_d;
    logic [4:0]      num_q, num_d;

    logic            hit_en, hit_pend, hit_ctrl, rd_drive, eoi;
    logic [NSRC-1:0] rise, active, ack_mask, w1c_mask;
    logic [4:0]      sel;
    logic [DBITS-1:0] rdata;

    assign hit_en   = (bus.address == ENBASE);
    assign hit_pend = (bus.address == PENDBASE);
    assign hit_ctrl = (bus.address == CTRLBASE);
    assign eoi      = bus.wrtEn && hit_ctrl && dbus[2];

    assign rise     = irqSrc & ~prev_q;
    assign active   = pend_q & en_q;
    assign ack_mask = (state_q == StReq && bus.intAck) ? (NSRC'(1) << num_q) : '0;
    assign w1c_mask = (bus.wrtEn && hit_pend) ? dbus[NSRC-1:0] : '0;

    // A rising edge always wins over any clear in the same cycle.
    assign pend_d = rise | (pend_q & ~ack_mask & ~w1c_mask);
    assign en_d   = (bus.wrtEn && hit_en) ? dbus[NSRC-1:0] : en_q;
    assign gie_d  = (bus.wrtEn && hit_ctrl) ? dbus[0] : gie_q;

    // Scan from the top so the lowest active index is the last one assigned.
    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) sel = 5'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        num_d   = num_q;
        unique case (state_q)
            StIdle: begin
                if (gie_q && |active) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    num_d   = sel;
                end
            end
            StReq: begin
                if (bus.intAck) begin
                    state_d = StService;
                    req_d   = 1'b0;
                end else if (!gie_q || !(|active)) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end else begin
                    num_d = sel;
                end
            end
            StService: begin
                if (eoi) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            en_q    <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            gie_q   <= 1'b0;
            req_q   <= 1'b0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            prev_q  <= irqSrc;
            gie_q   <= gie_d;
            req_q   <= req_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_en) begin
            rdata[NSRC-1:0] = en_q;
        end else if (hit_pend) begin
            rdata[NSRC-1:0] = pend_q;
        end else if (hit_ctrl) begin
            rdata[0]    = gie_q;
            rdata[1]    = (state_q == StService);
            rdata[12:8] = num_q;
        end
    end

    assign rd_drive   = !bus.wrtEn && (hit_en || hit_pend || hit_ctrl);
    assign dbus       = rd_drive ? rdata : 'z;
    assign bus.intReq = req_q;
    assign bus.intNum = num_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed handshake scenarios with literal expectations, then
// randomized bus/irq/ack traffic compared every cycle against a behavioural model.
module tb_intr_ctrl;

    localparam logic [31:0] ENB  = 32'hF000_0200;
    localparam logic [31:0] PNB  = 32'hF000_0204;
    localparam logic [31:0] CTB  = 32'hF000_0208;
    localparam logic [31:0] FREE = 32'hF000_0300;
    localparam logic [1:0]  M_IDLE = 2'd0, M_REQ = 2'd1, M_SERV = 2'd2;

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] pend;
        logic [7:0] prev;
        logic       gie;
        logic       req;
        logic [4:0] num;
        logic [1:0] mode;
    } mstate_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irqSrc = '0;
    logic [7:0]  cur_irq = '0;
    logic [31:0] tb_wdata = '0;
    logic        tb_oe = 1'b0;
    logic        chk_on = 1'b0;
    wire  [31:0] dbus;
    int          checks = 0;
    int          errors = 0;
    mstate_t     m;

    intr_ctrl_if #(.DBITS(32)) bus_if ();

    assign dbus = tb_oe ? tb_wdata : 'z;

    intr_ctrl #(.DBITS(32), .NSRC(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .dbus   (dbus),
        .irqSrc (irqSrc),
        .bus    (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic owned(input logic [31:0] a);
        return a == ENB || a == PNB || a == CTB;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [31:0] a,
                                           input logic we, input logic [31:0] d,
                                           input logic [7:0] irq, input logic ack);
        mstate_t    n = s;
        logic [7:0] act;
        logic [7:0] kept;
        int         low;
        kept = s.pend;
        if (s.mode == M_REQ && ack) kept = kept & ~(8'(1) << s.num);
        if (we && a == PNB) kept = kept & ~d[7:0];
        n.pend = kept | (irq & ~s.prev);
        n.prev = irq;
        if (we && a == ENB) n.en = d[7:0];
        if (we && a == CTB) n.gie = d[0];
        act = s.pend & s.en;
        low = 0;
        while (low < 8 && !act[low]) low++;
        case (s.mode)
            M_IDLE: if (s.gie && act != 0) begin
                n.mode = M_REQ; n.req = 1'b1; n.num = 5'(low);
            end
            M_REQ: if (ack) begin
                n.mode = M_SERV; n.req = 1'b0;
            end else if (!s.gie || act == 0) begin
                n.mode = M_IDLE; n.req = 1'b0;
            end else begin
                n.num = 5'(low);
            end
            default: if (we && a == CTB && d[2]) n.mode = M_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] model_read(input mstate_t s, input logic [31:0] a);
        if (a == ENB) return {24'd0, s.en};
        if (a == PNB) return {24'd0, s.pend};
        return (32'(s.num) << 8) | (32'(s.mode == M_SERV) << 1) | 32'(s.gie);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else m <= model_next(m, bus_if.address, bus_if.wrtEn, tb_wdata, irqSrc, bus_if.intAck);
    end

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            chk("intReq", 32'(bus_if.intReq), 32'(m.req));
            chk("intNum", 32'(bus_if.intNum), 32'(m.num));
            if (!bus_if.wrtEn && owned(bus_if.address))
                chk("rdata", dbus, model_read(m, bus_if.address));
            else if (!bus_if.wrtEn && tb_oe)
                chk("float", dbus, tb_wdata);
        end
    end

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d,
                         input logic oe, input logic ack);
        @(posedge clk);
        #2;
        bus_if.address = a;
        bus_if.wrtEn   = we;
        bus_if.intAck  = ack;
        tb_wdata       = d;
        tb_oe          = oe;
        irqSrc         = cur_irq;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d); drive(a, 1'b1, d, 1'b1, 1'b0); endtask
    task automatic rd(input logic [31:0] a); drive(a, 1'b0, '0, 1'b0, 1'b0); endtask
    task automatic idle(); drive(FREE, 1'b0, '0, 1'b0, 1'b0); endtask
    task automatic ackp(); drive(FREE, 1'b0, '0, 1'b0, 1'b1); endtask
    task automatic probe(input logic [31:0] a, input logic [31:0] d); drive(a, 1'b0, d, 1'b1, 1'b0); endtask

    // Sample outputs at the negedge of the cycle just driven.
    task automatic look(input string name, input logic req, input logic [4:0] num,
                        input logic [31:0] bus_exp, input logic chk_bus);
        @(negedge clk);
        chk({name, "_req"}, 32'(bus_if.intReq), 32'(req));
        chk({name, "_num"}, 32'(bus_if.intNum), 32'(num));
        if (chk_bus) chk({name, "_bus"}, dbus, bus_exp);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          op;
        bus_if.address = FREE;
        bus_if.wrtEn   = 1'b0;
        bus_if.intAck  = 1'b0;
        #1 reset = 1'b1;
        #20 reset = 1'b0;
        chk_on = 1'b1;

        // Single source request
        rd(CTB);            look("rst_ctrl", 1'b0, 5'd0, 32'h0, 1'b1);
        wr(ENB, 32'h01);
        wr(CTB, 32'h01);
        cur_irq = 8'h01; idle();
        cur_irq = 8'h00; idle();
        rd(PNB);            look("t1", 1'b1, 5'd0, 32'h01, 1'b1);

        // Acknowledge, service, EOI
        ackp();
        rd(CTB);            look("t2_busy", 1'b0, 5'd0, 32'h03, 1'b1);
        rd(PNB);            look("t2_pend", 1'b0, 5'd0, 32'h00, 1'b1);
        wr(CTB, 32'h05);
        rd(CTB);            look("t2_eoi", 1'b0, 5'd0, 32'h01, 1'b1);

        // Higher priority preempts before ack
        wr(ENB, 32'hFF);
        cur_irq = 8'h20; idle();
        cur_irq = 8'h24; idle();
        idle();             look("t3_first", 1'b1, 5'd5, 32'h0, 1'b0);
        idle();             look("t3_preempt", 1'b1, 5'd2, 32'h0, 1'b0);
        ackp();
        rd(PNB);            look("t3_pend", 1'b0, 5'd2, 32'h20, 1'b1);
        wr(CTB, 32'h05);
        idle();
        idle();             look("t3_second", 1'b1, 5'd5, 32'h0, 1'b0);
        ackp();
        wr(CTB, 32'h04);

        // Rise beats W1C; held level does not re-pend
        cur_irq = 8'h00; idle();
        cur_irq = 8'h08; wr(PNB, 32'h08);
        rd(PNB);            look("t4_rise_w1c", 1'b0, 5'd5, 32'h08, 1'b1);
        wr(PNB, 32'h08);
        idle(); idle();
        rd(PNB);            look("t4_held", 1'b0, 5'd5, 32'h00, 1'b1);

        // Withdraw request by clearing gie
        cur_irq = 8'h0A; wr(CTB, 32'h01);
        idle();
        idle();             look("t5_req", 1'b1, 5'd1, 32'h0, 1'b0);
        wr(CTB, 32'h00);
        idle();
        rd(PNB);            look("t5_drop", 1'b0, 5'd1, 32'h02, 1'b1);
        rd(ENB);            look("t5_en", 1'b0, 5'd1, 32'hFF, 1'b1);
        probe(32'hF000_020C, 32'h5A5A_1234);
        look("t5_float", 1'b0, 5'd1, 32'h5A5A_1234, 1'b1);

        // Async reset while in service
        cur_irq = 8'h0B; wr(CTB, 32'h01);
        idle();
        ackp();
        rd(CTB);            look("t6_serv", 1'b0, 5'd0, 32'h03, 1'b1);
        #1 reset = 1'b1;
        #1 chk("t6_req", 32'(bus_if.intReq), 32'h0);
        chk("t6_num", 32'(bus_if.intNum), 32'h0);
        bus_if.address = PNB; #1 chk("t6_pend", dbus, 32'h0);
        bus_if.address = ENB; #1 chk("t6_en", dbus, 32'h0);
        bus_if.address = CTB; #1 chk("t6_ctrl", dbus, 32'h0);
        #2 reset = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ (8'(1) << $urandom_range(0, 7));
            op = $urandom_range(0, 11);
            d  = $urandom;
            case (op)
                0, 1: begin d[0] = ($urandom_range(0, 4) != 0); wr(CTB, d); end
                2:    wr(ENB, d);
                3:    begin if ($urandom_range(0, 1) == 0) d = d & 32'h11; wr(PNB, d); end
                4:    rd(ENB);
                5:    rd(PNB);
                6:    rd(CTB);
                7, 8: ackp();
                9:    probe(ENB ^ (32'(1) << $urandom_range(4, 31)), d);
                10:   wr(ENB ^ (32'(1) << $urandom_range(4, 31)), d);
                default: idle();
            endcase
        end
        idle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
